reg_wb_arbiter: RTL and testbench

- Owns the single write port of the 8x8 register file.
- Shares that port between two writeback requesters: the ALU result and the data-memory load return.
- Uses round-robin arbitration with a registered output stage.
- Keeps a per-register pending-load scoreboard and raises HAZARD so the control path stalls reads and writes that would race an outstanding load.

---
 rtl/reg_wb_arbiter_pkg.sv | 7 +
 rtl/reg_scoreboard.sv | 38 +++
 rtl/reg_wb_arbiter.sv | 76 +++++++
 tb/tb_reg_wb_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg: shared widths and last-grant encoding for the writeback arbiter
package reg_wb_arbiter_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;
    typedef enum logic {GNT_ALU = 1'b0, GNT_LD = 1'b1} gnt_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-load bits with set-over-clear priority
module reg_scoreboard
    import reg_wb_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SET,
    input  logic [ADDR_W-1:0] SET_ADDR,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] CLR_ADDR,
    input  logic [ADDR_W-1:0] ISSUE_ADDR,
    output logic              ISSUE_READY,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    output logic              ALU_PEND,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    output logic              RD_PEND
);
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_n;

    assign ISSUE_READY = ~RESET & ~pending[ISSUE_ADDR];
    assign ALU_PEND    = pending[ALU_ADDR];
    assign RD_PEND     = pending[RD1_ADDR] | pending[RD2_ADDR];

    // clear first so a same-address issue in the same cycle keeps the bit set
    always_comb begin
        pending_n = pending;
        if (CLR) pending_n[CLR_ADDR] = 1'b0;
        if (SET) pending_n[SET_ADDR] = 1'b1;
    end

    // pending bit register
    always_ff @(posedge CLK) begin
        if (RESET) pending <= '0;
        else pending <= pending_n;
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin ALU/load arbiter for the register file write port
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALU_VALID,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    input  logic [DATA_W-1:0] ALU_DATA,
    output logic              ALU_READY,
    input  logic              LD_VALID,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              LD_READY,
    input  logic              ISSUE_VALID,
    input  logic [ADDR_W-1:0] ISSUE_ADDR,
    output logic              ISSUE_READY,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    input  logic              RD_EN,
    output logic              HAZARD,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN
);
    gnt_t last;
    logic alu_pend;
    logic rd_pend;
    logic alu_elig;
    logic ld_win;
    logic alu_win;

    reg_scoreboard u_sb (
        .CLK(CLK),
        .RESET(RESET),
        .SET(ISSUE_VALID & ISSUE_READY),
        .SET_ADDR(ISSUE_ADDR),
        .CLR(LD_READY),
        .CLR_ADDR(LD_ADDR),
        .ISSUE_ADDR(ISSUE_ADDR),
        .ISSUE_READY(ISSUE_READY),
        .ALU_ADDR(ALU_ADDR),
        .ALU_PEND(alu_pend),
        .RD1_ADDR(RD1_ADDR),
        .RD2_ADDR(RD2_ADDR),
        .RD_PEND(rd_pend)
    );

    // ALU is held off its destination while a load to it is outstanding
    assign alu_elig  = ALU_VALID & ~alu_pend;
    assign ld_win    = LD_VALID & (~alu_elig | (last == GNT_ALU));
    assign alu_win   = alu_elig & ~ld_win;
    assign ALU_READY = ~RESET & alu_win;
    assign LD_READY  = ~RESET & ld_win;
    assign HAZARD    = RD_EN & (rd_pend | (WRITE & ((INADDRESS == RD1_ADDR) | (INADDRESS == RD2_ADDR))));

    // registered write stage; the pointer moves only when both requesters competed
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
            last      <= GNT_ALU;
        end else begin
            WRITE <= ALU_READY | LD_READY;
            if (LD_READY) begin
                INADDRESS <= LD_ADDR;
                IN        <= LD_DATA;
            end else if (ALU_READY) begin
                INADDRESS <= ALU_ADDR;
                IN        <= ALU_DATA;
            end
            if (alu_elig & LD_VALID) last <= ld_win ? GNT_LD : GNT_ALU;
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed scoreboard bench for the writeback arbiter
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              ALU_VALID, LD_VALID, ISSUE_VALID, RD_EN;
    logic [ADDR_W-1:0] ALU_ADDR, LD_ADDR, ISSUE_ADDR, RD1_ADDR, RD2_ADDR;
    logic [DATA_W-1:0] ALU_DATA, LD_DATA;
    logic              ALU_READY, LD_READY, ISSUE_READY, HAZARD, WRITE;
    logic [ADDR_W-1:0] INADDRESS;
    logic [DATA_W-1:0] IN;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    reg_wb_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
        .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_READY(LD_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR), .ISSUE_READY(ISSUE_READY),
        .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR), .RD_EN(RD_EN), .HAZARD(HAZARD),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic tick();
        logic [ADDR_W+DATA_W-1:0] e;
        @(posedge CLK);
        @(negedge CLK);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("write", WRITE, 1);
            check("waddr", INADDRESS, e[ADDR_W+DATA_W-1:DATA_W]);
            check("wdata", IN, e[DATA_W-1:0]);
        end else check("write_idle", WRITE, 0);
    endtask

    task automatic idle();
        ALU_VALID = 0; LD_VALID = 0; ISSUE_VALID = 0; RD_EN = 0;
    endtask

    initial begin
        RESET = 1; idle();
        ALU_ADDR = 0; ALU_DATA = 0; LD_ADDR = 0; LD_DATA = 0;
        ISSUE_ADDR = 0; RD1_ADDR = 0; RD2_ADDR = 0;
        ALU_VALID = 1; LD_VALID = 1;
        tick(); tick();
        check("rst_alu_ready", ALU_READY, 0);
        check("rst_ld_ready", LD_READY, 0);
        check("rst_inaddr", INADDRESS, 0);
        check("rst_in", IN, 0);
        RESET = 0; idle();
        // single ALU write
        ALU_VALID = 1; ALU_ADDR = 3; ALU_DATA = 8'h2A; #1;
        check("alu_ready", ALU_READY, 1);
        push(3, 8'h2A);
        tick(); idle();
        tick();
        check("hold_addr", INADDRESS, 3);
        check("hold_data", IN, 8'h2A);
        // contention after reset: load first, then ALU, then ALU wins next contention
        ALU_VALID = 1; ALU_ADDR = 1; ALU_DATA = 8'h11;
        LD_VALID = 1; LD_ADDR = 2; LD_DATA = 8'h22; #1;
        check("c1_ld_ready", LD_READY, 1);
        check("c1_alu_ready", ALU_READY, 0);
        push(2, 8'h22);
        tick(); LD_VALID = 0; #1;
        check("c1_alu_turn", ALU_READY, 1);
        push(1, 8'h11);
        tick();
        ALU_DATA = 8'h33; LD_VALID = 1; LD_DATA = 8'h44; #1;
        check("c2_alu_ready", ALU_READY, 1);
        check("c2_ld_ready", LD_READY, 0);
        push(1, 8'h33);
        tick(); ALU_VALID = 0; #1;
        check("c2_ld_turn", LD_READY, 1);
        push(2, 8'h44);
        tick(); idle(); tick();
        // pending r5 and hazard through the landing write
        ISSUE_VALID = 1; ISSUE_ADDR = 5; #1;
        check("iss5_ready", ISSUE_READY, 1);
        tick(); #1;
        check("iss5_again", ISSUE_READY, 0);
        ISSUE_VALID = 0; RD1_ADDR = 5; RD2_ADDR = 0; #1;
        check("hz_rd_en_off", HAZARD, 0);
        RD_EN = 1; #1;
        check("hz_rd1", HAZARD, 1);
        RD1_ADDR = 0; RD2_ADDR = 5; #1;
        check("hz_rd2", HAZARD, 1);
        RD1_ADDR = 5; RD2_ADDR = 0;
        LD_VALID = 1; LD_ADDR = 5; LD_DATA = 8'h7F; #1;
        check("ld5_ready", LD_READY, 1);
        check("hz_ld_accept", HAZARD, 1);
        push(5, 8'h7F);
        tick(); LD_VALID = 0; #1;
        check("hz_write_cycle", HAZARD, 1);
        tick(); #1;
        check("hz_clear", HAZARD, 0);
        idle();
        // ALU to a pending register waits for the load
        ISSUE_VALID = 1; ISSUE_ADDR = 4;
        tick(); ISSUE_VALID = 0;
        ALU_VALID = 1; ALU_ADDR = 4; ALU_DATA = 8'h55; #1;
        check("waw_block0", ALU_READY, 0);
        tick(); #1;
        check("waw_block1", ALU_READY, 0);
        LD_VALID = 1; LD_ADDR = 4; LD_DATA = 8'h66; #1;
        check("waw_ld_ready", LD_READY, 1);
        check("waw_alu_wait", ALU_READY, 0);
        push(4, 8'h66);
        tick(); LD_VALID = 0; #1;
        check("waw_alu_go", ALU_READY, 1);
        push(4, 8'h55);
        tick(); idle();
        // set wins over clear on the same address
        ISSUE_VALID = 1; ISSUE_ADDR = 6;
        LD_VALID = 1; LD_ADDR = 6; LD_DATA = 8'h01; #1;
        check("sc_issue_ready", ISSUE_READY, 1);
        check("sc_ld_ready", LD_READY, 1);
        push(6, 8'h01);
        tick(); idle(); #1;
        check("sc_pending", ISSUE_READY, 0);
        tick();
        RD_EN = 1; RD1_ADDR = 6; RD2_ADDR = 6; #1;
        check("sc_hazard", HAZARD, 1);
        idle();
        // leave the pointer at LD, hold r0 pending, then reset mid-write
        ALU_VALID = 1; ALU_ADDR = 1; ALU_DATA = 8'hA1;
        LD_VALID = 1; LD_ADDR = 2; LD_DATA = 8'hB2;
        ISSUE_VALID = 1; ISSUE_ADDR = 0; #1;
        check("pre_ld_ready", LD_READY, 1);
        push(2, 8'hB2);
        tick(); idle();
        ALU_VALID = 1; ALU_ADDR = 7; ALU_DATA = 8'h99; #1;
        check("pre_alu_ready", ALU_READY, 1);
        push(7, 8'h99);
        tick();
        RESET = 1; #1;
        check("rst_ready_low", ALU_READY, 0);
        tick();
        check("post_rst_addr", INADDRESS, 0);
        check("post_rst_data", IN, 0);
        RESET = 0; idle(); ISSUE_ADDR = 0; #1;
        check("post_rst_r0", ISSUE_READY, 1);
        ISSUE_ADDR = 6; RD_EN = 1; RD1_ADDR = 6; RD2_ADDR = 6; #1;
        check("post_rst_r6", ISSUE_READY, 1);
        check("post_rst_hz", HAZARD, 0);
        idle();
        ALU_VALID = 1; ALU_ADDR = 1; ALU_DATA = 8'hC3;
        LD_VALID = 1; LD_ADDR = 2; LD_DATA = 8'hD4; #1;
        check("post_rst_ld_first", LD_READY, 1);
        push(2, 8'hD4);
        tick(); idle(); tick();
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
